dpram_loader: RTL

Write-side front end for a `dpram` port: accepts a byte stream from the host download channel (ROM/BRAM image load), packs bytes little-endian into `data_width` words and writes them sequentially into one port of a `dpram` instance. It also provides a clear mode that fills the whole RAM with a constant. The core reads the other port; this block owns the write port exclusively.

---
 rtl/dpram_loader_if.sv | 32 +++
 rtl/dpram_loader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dpram_loader_if.sv
// Download/RAM-write bundle between a host download channel and dpram_loader.
// master = host side (issues commands and bytes), slave = the loader.
interface dpram_loader_if #(
  parameter int addr_width = 8,
  parameter int data_width = 16
);
  logic                  start;
  logic                  clear;
  logic                  dl_valid;
  logic [7:0]            dl_data;
  logic                  dl_last;
  logic                  dl_ready;
  logic [addr_width-1:0] ram_address;
  logic [data_width-1:0] ram_data;
  logic                  ram_wren;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [addr_width:0]   words_written;

  modport master (
    output start, clear, dl_valid, dl_data, dl_last,
    input  dl_ready, ram_address, ram_data, ram_wren,
           busy, done, overflow, words_written
  );

  modport slave (
    input  start, clear, dl_valid, dl_data, dl_last,
    output dl_ready, ram_address, ram_data, ram_wren,
           busy, done, overflow, words_written
  );
endinterface

// File: rtl/dpram_loader.sv
// Write-port front end for a dpram: packs a download byte stream little-endian
// into RAM words and writes them sequentially, or fills the RAM with a constant.
module dpram_loader #(
  parameter int                    addr_width  = 8,
  parameter int                    data_width  = 16,
  parameter int                    NUMWORDS    = 1 << addr_width,
  parameter logic [7:0]            pad_byte    = 8'hFF,
  parameter logic [data_width-1:0] clear_value = '0
) (
  input logic           clock,
  input logic           reset_n,
  dpram_loader_if.slave bus
);

  localparam int BPW    = data_width / 8;
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LANE_W-1:0]   LAST_LANE  = LANE_W'(BPW - 1);
  localparam logic [addr_width:0] WORD_LIMIT = (addr_width + 1)'(NUMWORDS);

  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, FIN} state_t;

  state_t                state;
  logic [LANE_W-1:0]     lane;
  logic [data_width-1:0] pack;
  logic [data_width-1:0] next_word;
  logic [addr_width:0]   word_addr;
  logic                  last_pending;
  logic                  accept;
  logic                  word_complete;
  logic                  room_left;

  assign accept        = (state == LOAD) && bus.dl_valid && bus.dl_ready;
  assign word_complete = (lane == LAST_LANE) || bus.dl_last;
  assign room_left     = (word_addr != WORD_LIMIT);

  // Merge the incoming byte into its lane; a short final word pads the lanes above it.
  always_comb begin
    next_word = pack;
    for (int i = 0; i < BPW; i++) begin
      if (i == int'(lane))
        next_word[8*i +: 8] = bus.dl_data;
      else if (bus.dl_last && (i > int'(lane)))
        next_word[8*i +: 8] = pad_byte;
    end
  end

  // words_written follows committed writes, so it is already final when done rises.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state             <= IDLE;
      lane              <= '0;
      pack              <= '0;
      word_addr         <= '0;
      last_pending      <= 1'b0;
      bus.dl_ready      <= 1'b0;
      bus.ram_address   <= '0;
      bus.ram_data      <= '0;
      bus.ram_wren      <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.overflow      <= 1'b0;
      bus.words_written <= '0;
    end else begin
      bus.ram_wren <= 1'b0;
      bus.done     <= 1'b0;
      if (bus.ram_wren)
        bus.words_written <= bus.words_written + 1'b1;

      case (state)
        IDLE: begin
          if (bus.clear) begin
            state             <= CLEAR;
            bus.busy          <= 1'b1;
            lane              <= '0;
            bus.overflow      <= 1'b0;
            bus.words_written <= '0;
            bus.ram_wren      <= 1'b1;
            bus.ram_address   <= '0;
            bus.ram_data      <= clear_value;
            word_addr         <= (addr_width + 1)'(1);
          end else if (bus.start) begin
            state             <= LOAD;
            bus.busy          <= 1'b1;
            bus.dl_ready      <= 1'b1;
            lane              <= '0;
            bus.overflow      <= 1'b0;
            bus.words_written <= '0;
            word_addr         <= '0;
          end
        end

        LOAD: begin
          if (last_pending) begin
            state        <= FIN;
            last_pending <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
          end else if (accept) begin
            if (word_complete) begin
              lane <= '0;
              if (room_left) begin
                bus.ram_wren    <= 1'b1;
                bus.ram_data    <= next_word;
                bus.ram_address <= word_addr[addr_width-1:0];
                word_addr       <= word_addr + 1'b1;
              end else begin
                bus.overflow <= 1'b1;
              end
            end else begin
              lane <= lane + 1'b1;
              pack <= next_word;
            end

            // With a final write in flight, finish one cycle later so done follows the commit.
            if (bus.dl_last) begin
              bus.dl_ready <= 1'b0;
              if (room_left) begin
                last_pending <= 1'b1;
              end else begin
                state    <= FIN;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
              end
            end
          end
        end

        CLEAR: begin
          if (room_left) begin
            bus.ram_wren    <= 1'b1;
            bus.ram_data    <= clear_value;
            bus.ram_address <= word_addr[addr_width-1:0];
            word_addr       <= word_addr + 1'b1;
          end else begin
            state    <= FIN;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
